// File: rtl/i2s_rx_lite.sv
// ---------------------------------------------------------------------------
// i2s_rx_lite
//
// Purpose: receives a two-channel serial audio stream (left-justified or
// Philips I2S, selected by DELAY), recovers one left and one right word per
// frame and presents them together on the system clock. Malformed frames
// (lrclk toggling before a word is complete) are flagged and counted.
//
// Parameters:
//   WIDTH  bits per channel word (8..32)
//   DELAY  bclk samples skipped after each lrclk edge before the MSB
//          (0 = left-justified, 1 = Philips I2S)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i2s_bclk   in   serial bit clock (asynchronous to clk)
//   i2s_lrclk  in   word select, 1 = left, 0 = right
//   i2s_data   in   serial data, MSB first
//   out_left   out  last complete left word
//   out_right  out  last complete right word
//   out_valid  out  one-clk pulse when out_left/out_right update
//   frame_err  out  one-clk pulse on a malformed frame
//   err_cnt    out  saturating count of frame_err pulses
//   locked     out  high after a good frame, low after any error
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module i2s_rx_lite #(
  parameter int WIDTH = 24,
  parameter int DELAY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i2s_bclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_data,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  output logic             out_valid,
  output logic             frame_err,
  output logic [7:0]       err_cnt,
  output logic             locked
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [CW-1:0] FULL      = CW'(WIDTH);
  localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
  localparam logic [SW-1:0] SKIP_INIT = SW'(DELAY);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, WAIT_L} state_t;

  state_t state_q, state_d;

  // Synchronizers: bclk gets a third stage so its falling edge can be seen
  // in the same cycle that lrclk/data leave their (equal-depth) chains.
  logic [2:0] bclk_sync_q, bclk_sync_d;
  logic [1:0] lr_sync_q, lr_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;

  logic             prev_lr_q, prev_lr_d;
  // prev_lr is meaningless until one sample has been taken after reset;
  // without this a reset released mid-left-word would look like a rising edge.
  logic             prev_ok_q, prev_ok_d;
  logic [SW-1:0]    skip_q, skip_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] out_left_q, out_left_d;
  logic [WIDTH-1:0] out_right_q, out_right_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;

  // Event decode
  logic             sample, lr_s, dat_s, rise, fall, left_full, last_bit;
  logic [WIDTH-1:0] shifted;

  // FSM control outputs
  logic reload, consume, err_ev, latch_left, emit;

  // Per-sample working values (after an optional counter reload)
  logic [SW-1:0]    sk_base;
  logic [CW-1:0]    cnt_base;
  logic [WIDTH-1:0] sh_base;

  always_comb begin
    sample    = bclk_sync_q[2] & ~bclk_sync_q[1];
    lr_s      = lr_sync_q[1];
    dat_s     = dat_sync_q[1];
    rise      = sample & prev_ok_q & lr_s & ~prev_lr_q;
    fall      = sample & prev_ok_q & ~lr_s & prev_lr_q;
    left_full = (cnt_q == FULL);
    // The current sample would be the final bit of the word in progress.
    last_bit  = (skip_q == '0) && (cnt_q == LAST);
    shifted   = {shift_q[WIDTH-2:0], dat_s};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = LEFT;
      end
      LEFT: begin
        if (fall && left_full) state_d = RIGHT;
        else if (rise)         state_d = LEFT;
        else if (fall)         state_d = IDLE;
      end
      RIGHT: begin
        if (rise)                     state_d = LEFT;
        else if (fall)                state_d = IDLE;
        else if (sample && last_bit)  state_d = WAIT_L;
      end
      WAIT_L: begin
        if (rise) state_d = LEFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. An lrclk edge that starts a channel is itself processed as
  // a data sample, so with DELAY=0 it carries the MSB.
  always_comb begin
    reload     = 1'b0;
    consume    = 1'b0;
    err_ev     = 1'b0;
    latch_left = 1'b0;
    emit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          reload  = 1'b1;
          consume = 1'b1;
        end
      end
      LEFT: begin
        if (fall && left_full) begin
          reload  = 1'b1;
          consume = 1'b1;
        end else if (rise || fall) begin
          err_ev = 1'b1;
          if (rise) begin
            reload  = 1'b1;
            consume = 1'b1;
          end
        end else if (sample && !left_full) begin
          // Bits past WIDTH are simply ignored until lrclk falls.
          consume    = 1'b1;
          latch_left = last_bit;
        end
      end
      RIGHT: begin
        if (rise || fall) begin
          err_ev = 1'b1;
          if (rise) begin
            reload  = 1'b1;
            consume = 1'b1;
          end
        end else if (sample) begin
          consume = 1'b1;
          emit    = last_bit;
        end
      end
      WAIT_L: begin
        if (rise) begin
          reload  = 1'b1;
          consume = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], i2s_bclk};
    lr_sync_d   = {lr_sync_q[0], i2s_lrclk};
    dat_sync_d  = {dat_sync_q[0], i2s_data};

    prev_lr_d = prev_lr_q;
    prev_ok_d = prev_ok_q;
    if (sample) begin
      prev_lr_d = lr_s;
      prev_ok_d = 1'b1;
    end

    sk_base  = reload ? SKIP_INIT : skip_q;
    cnt_base = reload ? '0 : cnt_q;
    sh_base  = reload ? '0 : shift_q;

    skip_d  = skip_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (err_ev) begin
      skip_d  = '0;
      cnt_d   = '0;
      shift_d = '0;
    end
    if (consume) begin
      if (sk_base != '0) begin
        skip_d  = sk_base - SW'(1);
        cnt_d   = cnt_base;
        shift_d = sh_base;
      end else begin
        skip_d  = '0;
        cnt_d   = cnt_base + CW'(1);
        shift_d = {sh_base[WIDTH-2:0], dat_s};
      end
    end

    hold_d = hold_q;
    if (latch_left) hold_d = shifted;

    // Both output words are loaded in the same cycle so they never disagree.
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    if (emit) begin
      out_left_d  = hold_q;
      out_right_d = shifted;
    end
    out_valid_d = emit;
    frame_err_d = err_ev;

    locked_d = locked_q;
    if (emit)        locked_d = 1'b1;
    else if (err_ev) locked_d = 1'b0;

    err_cnt_d = err_cnt_q;
    if (err_ev && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      dat_sync_q  <= '0;
      prev_lr_q   <= 1'b0;
      prev_ok_q   <= 1'b0;
      skip_q      <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      dat_sync_q  <= dat_sync_d;
      prev_lr_q   <= prev_lr_d;
      prev_ok_q   <= prev_ok_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx_lite.sv
`timescale 1ns/1ps

module tb_i2s_rx_lite;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk = 1'b0;
  logic lrclk = 1'b0;
  logic data = 1'b0;

  logic [23:0] l0, r0, l1, r1;
  logic        v0, v1, fe0, fe1, lk0, lk1;
  logic [7:0]  ec0, ec1;

  int total = 0;
  int bad = 0;

  logic [23:0] ql0[$];
  logic [23:0] qr0[$];
  logic [23:0] ql1[$];
  logic [23:0] qr1[$];
  int errs0 = 0;

  always #5 clk = ~clk;

  i2s_rx_lite #(.WIDTH(24), .DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data),
    .out_left(l0), .out_right(r0), .out_valid(v0), .frame_err(fe0),
    .err_cnt(ec0), .locked(lk0)
  );

  i2s_rx_lite #(.WIDTH(24), .DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data),
    .out_left(l1), .out_right(r1), .out_valid(v1), .frame_err(fe1),
    .err_cnt(ec1), .locked(lk1)
  );

  // Collect output pulses, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (v0) begin
      ql0.push_back(l0);
      qr0.push_back(r0);
      $display("[%0t] dut0 out_valid L=%h R=%h", $time, l0, r0);
    end
    if (v1) begin
      ql1.push_back(l1);
      qr1.push_back(r1);
      $display("[%0t] dut1 out_valid L=%h R=%h", $time, l1, r1);
    end
    if (fe0) errs0 <= errs0 + 1;
  end

  // One bclk period (8 clk): lrclk/data change on the rising edge, the
  // receiver samples on the falling edge.
  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b1;
    lrclk = lr;
    data = d;
    #40;
    bclk = 1'b0;
    #40;
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++) send_bit(1'b0, 1'b0);
  endtask

  // Left-justified frame, slot bclks per channel, zero padding after the LSB.
  task automatic send_lj(input logic [23:0] lw, input logic [23:0] rw, input int slot);
    for (int k = 0; k < slot; k++) begin
      if (k < 24) send_bit(1'b1, lw[23-k]);
      else        send_bit(1'b1, 1'b0);
    end
    for (int k = 0; k < slot; k++) begin
      if (k < 24) send_bit(1'b0, rw[23-k]);
      else        send_bit(1'b0, 1'b0);
    end
  endtask

  // Philips frame, 32-bclk slots: MSB one bclk after the lrclk edge.
  task automatic send_philips(input logic [23:0] lw, input logic [23:0] rw);
    for (int k = 0; k < 32; k++) begin
      if (k >= 1 && k <= 24) send_bit(1'b1, lw[24-k]);
      else                   send_bit(1'b1, 1'b0);
    end
    for (int k = 0; k < 32; k++) begin
      if (k >= 1 && k <= 24) send_bit(1'b0, rw[24-k]);
      else                   send_bit(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    total++; if (l0 !== 24'h0) begin bad++; $display("FAIL reset_out_left: got %h want %h", l0, 24'h0); end
    total++; if (r0 !== 24'h0) begin bad++; $display("FAIL reset_out_right: got %h want %h", r0, 24'h0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", v0); end
    total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", fe0); end
    total++; if (ec0 !== 8'h0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", ec0); end
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", lk0); end
    #20;
    rst_n = 1'b1;
    #20;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int n0, e0;
    logic [23:0] gl, gr;
    n0 = ql0.size();
    e0 = errs0;
    idle_bits(4);
    send_lj(24'hA5A5A5, 24'h5A5A5A, 32);
    idle_bits(2);
    total++; if (ql0.size() !== n0 + 1) begin bad++; $display("FAIL single_pulses: got %0d want %0d", ql0.size() - n0, 1); end
    gl = (ql0.size() > n0) ? ql0[n0] : 24'hxxxxxx;
    gr = (qr0.size() > n0) ? qr0[n0] : 24'hxxxxxx;
    total++; if (gl !== 24'hA5A5A5) begin bad++; $display("FAIL single_left: got %h want %h", gl, 24'hA5A5A5); end
    total++; if (gr !== 24'h5A5A5A) begin bad++; $display("FAIL single_right: got %h want %h", gr, 24'h5A5A5A); end
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL single_locked: got %b want 1", lk0); end
    total++; if (ec0 !== 8'd0) begin bad++; $display("FAIL single_err_cnt: got %0d want 0", ec0); end
    total++; if (errs0 !== e0) begin bad++; $display("FAIL single_frame_err: got %0d want 0", errs0 - e0); end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_l [3];
    logic [23:0] exp_r [3];
    logic [23:0] gl, gr;
    int n0, e0;
    exp_l[0] = 24'h000001; exp_r[0] = 24'h800000;
    exp_l[1] = 24'hFFFFFF; exp_r[1] = 24'h000000;
    exp_l[2] = 24'h123456; exp_r[2] = 24'hABCDEF;
    n0 = ql0.size();
    e0 = errs0;
    // Slots exactly WIDTH long: lrclk toggles on the bit right after the LSB.
    for (int f = 0; f < 3; f++) send_lj(exp_l[f], exp_r[f], 24);
    idle_bits(2);
    total++; if (ql0.size() !== n0 + 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", ql0.size() - n0); end
    for (int f = 0; f < 3; f++) begin
      gl = (ql0.size() > n0 + f) ? ql0[n0+f] : 24'hxxxxxx;
      gr = (qr0.size() > n0 + f) ? qr0[n0+f] : 24'hxxxxxx;
      total++; if (gl !== exp_l[f]) begin bad++; $display("FAIL b2b_left%0d: got %h want %h", f, gl, exp_l[f]); end
      total++; if (gr !== exp_r[f]) begin bad++; $display("FAIL b2b_right%0d: got %h want %h", f, gr, exp_r[f]); end
    end
    total++; if (errs0 !== e0) begin bad++; $display("FAIL b2b_frame_err: got %0d want 0", errs0 - e0); end
    $display("test_back_to_back done");
  endtask

  task automatic test_short_left();
    int n0, e0;
    logic [23:0] gl, gr;
    n0 = ql0.size();
    e0 = errs0;
    for (int k = 0; k < 20; k++) send_bit(1'b1, 1'b1);
    idle_bits(32);
    total++; if (errs0 !== e0 + 1) begin bad++; $display("FAIL short_frame_err: got %0d want 1", errs0 - e0); end
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL short_locked: got %b want 0", lk0); end
    total++; if (ec0 !== 8'd1) begin bad++; $display("FAIL short_err_cnt: got %0d want 1", ec0); end
    total++; if (ql0.size() !== n0) begin bad++; $display("FAIL short_no_valid: got %0d want 0", ql0.size() - n0); end
    total++; if (l0 !== 24'h123456) begin bad++; $display("FAIL short_hold_left: got %h want %h", l0, 24'h123456); end
    total++; if (r0 !== 24'hABCDEF) begin bad++; $display("FAIL short_hold_right: got %h want %h", r0, 24'hABCDEF); end
    send_lj(24'h13579B, 24'h2468AC, 32);
    idle_bits(2);
    total++; if (ql0.size() !== n0 + 1) begin bad++; $display("FAIL short_recover_pulses: got %0d want 1", ql0.size() - n0); end
    gl = (ql0.size() > n0) ? ql0[n0] : 24'hxxxxxx;
    gr = (qr0.size() > n0) ? qr0[n0] : 24'hxxxxxx;
    total++; if (gl !== 24'h13579B) begin bad++; $display("FAIL short_recover_left: got %h want %h", gl, 24'h13579B); end
    total++; if (gr !== 24'h2468AC) begin bad++; $display("FAIL short_recover_right: got %h want %h", gr, 24'h2468AC); end
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL short_recover_locked: got %b want 1", lk0); end
    $display("test_short_left done");
  endtask

  task automatic test_philips();
    int n0, n1;
    logic [23:0] gl, gr;
    idle_bits(4);
    n0 = ql0.size();
    n1 = ql1.size();
    send_philips(24'hC0FFEE, 24'h0BEEF0);
    idle_bits(2);
    total++; if (ql1.size() !== n1 + 1) begin bad++; $display("FAIL philips_d1_pulses: got %0d want 1", ql1.size() - n1); end
    gl = (ql1.size() > n1) ? ql1[n1] : 24'hxxxxxx;
    gr = (qr1.size() > n1) ? qr1[n1] : 24'hxxxxxx;
    total++; if (gl !== 24'hC0FFEE) begin bad++; $display("FAIL philips_d1_left: got %h want %h", gl, 24'hC0FFEE); end
    total++; if (gr !== 24'h0BEEF0) begin bad++; $display("FAIL philips_d1_right: got %h want %h", gr, 24'h0BEEF0); end
    // DELAY=0 takes the pad bit as MSB, so each word appears shifted right by one.
    total++; if (ql0.size() !== n0 + 1) begin bad++; $display("FAIL philips_d0_pulses: got %0d want 1", ql0.size() - n0); end
    gl = (ql0.size() > n0) ? ql0[n0] : 24'hxxxxxx;
    gr = (qr0.size() > n0) ? qr0[n0] : 24'hxxxxxx;
    total++; if (gl !== 24'h607FF7) begin bad++; $display("FAIL philips_d0_left: got %h want %h", gl, 24'h607FF7); end
    total++; if (gr !== 24'h05F778) begin bad++; $display("FAIL philips_d0_right: got %h want %h", gr, 24'h05F778); end
    $display("test_philips done");
  endtask

  task automatic test_reset_midframe();
    int n0;
    logic [23:0] w;
    logic [23:0] gl, gr;
    w = 24'h111111;
    for (int k = 0; k < 10; k++) send_bit(1'b1, w[23-k]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (l0 !== 24'h0) begin bad++; $display("FAIL midrst_async_left: got %h want %h", l0, 24'h0); end
    total++; if (ec0 !== 8'd0) begin bad++; $display("FAIL midrst_async_err_cnt: got %0d want 0", ec0); end
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL midrst_async_locked: got %b want 0", lk0); end
    #30;
    rst_n = 1'b1;
    n0 = ql0.size();
    for (int k = 10; k < 24; k++) send_bit(1'b1, w[23-k]);
    for (int k = 0; k < 32; k++) send_bit(1'b0, 1'b1);
    total++; if (ql0.size() !== n0) begin bad++; $display("FAIL midrst_no_valid: got %0d want 0", ql0.size() - n0); end
    send_lj(24'h0F0F0F, 24'hF0F0F0, 32);
    idle_bits(2);
    total++; if (ql0.size() !== n0 + 1) begin bad++; $display("FAIL midrst_next_pulses: got %0d want 1", ql0.size() - n0); end
    gl = (ql0.size() > n0) ? ql0[n0] : 24'hxxxxxx;
    gr = (qr0.size() > n0) ? qr0[n0] : 24'hxxxxxx;
    total++; if (gl !== 24'h0F0F0F) begin bad++; $display("FAIL midrst_next_left: got %h want %h", gl, 24'h0F0F0F); end
    total++; if (gr !== 24'hF0F0F0) begin bad++; $display("FAIL midrst_next_right: got %h want %h", gr, 24'hF0F0F0); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_saturation();
    int e0;
    int c0;
    e0 = errs0;
    c0 = int'(ec0);
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) send_bit(1'b0, 1'b0);
      if (i == 253) begin
        total++; if (ec0 !== 8'(c0 + 254)) begin bad++; $display("FAIL sat_err_cnt_254: got %0d want %0d", ec0, c0 + 254); end
      end
    end
    idle_bits(2);
    total++; if (ec0 !== 8'hFF) begin bad++; $display("FAIL sat_err_cnt: got %0d want 255", ec0); end
    total++; if (errs0 !== e0 + 300) begin bad++; $display("FAIL sat_frame_err_pulses: got %0d want 300", errs0 - e0); end
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL sat_locked: got %b want 0", lk0); end
    $display("test_saturation done");
  endtask

  initial begin
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_short_left();
    test_philips();
    test_reset_midframe();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_lite.md
I2S_RX_LITE -- requirements
Module: i2s_rx_lite

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning bits per channel word (range 8..32).
REQ-002 SHALL have parameter DELAY, default 0, meaning bclk samples skipped after each lrclk edge before the MSB (0 = left-justified, 1 = Philips I2S).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i2s_bclk  input  1  serial bit clock, asynchronous to clk.
REQ-006 SHALL have port i2s_lrclk  input  1  word select: 1 = left, 0 = right.
REQ-007 SHALL have port i2s_data  input  1  serial data, MSB first.
REQ-008 SHALL have port out_left  output  WIDTH  last complete left word.
REQ-009 SHALL have port out_right  output  WIDTH  last complete right word.
REQ-010 SHALL have port out_valid  output  1  one-clk pulse when out_left/out_right update together.
REQ-011 SHALL have port frame_err  output  1  one-clk pulse on a malformed frame.
REQ-012 SHALL have port err_cnt  output  8  saturating count of frame_err pulses.
REQ-013 SHALL have port locked  output  1  high after the first good frame, low after any error.

Function
REQ-014 SHALL pass i2s_bclk, i2s_lrclk and i2s_data through 2-flop synchronizers of equal depth; a third bclk flop SHALL provide edge detection.
REQ-015 SHALL sample synchronized lrclk and data on each detected bclk falling edge (sample event); no other clk cycle samples.
REQ-016 Operation SHALL be specified for f_clk >= 4 x f_bclk; lower ratios are unsupported.
REQ-017 SHALL track prev_lr, the lrclk value at the previous sample event.
REQ-018 SHALL implement states IDLE, LEFT, RIGHT, WAIT_L.
REQ-019 IDLE: ignore data; on a sample event with lrclk=1 and prev_lr=0 -> LEFT, with skip counter = DELAY and bit counter = 0.
REQ-020 LEFT/RIGHT: each sample event first decrements a nonzero skip counter; otherwise it shifts data into the channel shift register LSB-side and increments the bit counter.
REQ-021 LEFT: when the bit counter reaches WIDTH, latch the left word into a holding register; later samples with lrclk=1 are ignored.
REQ-022 LEFT: on an lrclk 1->0 sample event -> RIGHT with counters reloaded; this event is also the first right-channel bit when DELAY=0.
REQ-023 RIGHT: when the bit counter reaches WIDTH, drive out_left = held left word and out_right = right word, pulse out_valid the next clk, set locked, -> WAIT_L.
REQ-024 WAIT_L: ignore samples with lrclk=0; on a 0->1 sample event -> LEFT with counters reloaded; that event is the left MSB when DELAY=0.
REQ-025 An lrclk edge in LEFT or RIGHT before the bit counter reaches WIDTH SHALL pulse frame_err, clear locked, discard partial words, and -> LEFT on a 0->1 edge or -> IDLE on a 1->0 edge.
REQ-026 An lrclk 1->0 edge in LEFT before the left word completes is covered by REQ-025; excess left bits beyond WIDTH SHALL NOT raise an error.
REQ-027 out_left/out_right SHALL hold their values between out_valid pulses and SHALL never update partially.
REQ-028 err_cnt SHALL increment on each frame_err pulse and saturate at 255.
REQ-029 Latency: out_valid SHALL assert at most 5 clk after the bclk falling edge that carries the last right bit at the pin.

Reset
REQ-030 On rst_n low, all outputs, synchronizers, counters and shift registers SHALL clear to 0 and the state SHALL be IDLE, immediately and regardless of clk.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, no out_valid SHALL occur before a new lrclk 0->1 edge.

Verification
- WIDTH=24, DELAY=0, clk = 8 x bclk, L=0xA5A5A5, R=0x5A5A5A -> one out_valid, values exact, locked=1, err_cnt=0.
- 3 back-to-back frames (0x000001/0x800000, 0xFFFFFF/0x000000, 0x123456/0xABCDEF) -> 3 pulses in order, no frame_err.
- lrclk falls after 20 left bits -> frame_err pulse, locked=0, err_cnt=1, outputs unchanged; next good frame -> out_valid, locked=1.
- DELAY=1, Philips framing with 0xC0FFEE/0x0BEEF0 -> exact capture; same stream with DELAY=0 -> values shifted by one bit.
- rst_n pulse at left bit 10, stream continues -> no out_valid for the partial frame; first pulse follows the next lrclk rise.
- 300 forced short frames -> err_cnt saturates at 255.
